// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked scheduler that shares one UART transmitter between
// NUM_REQ byte-stream requesters, one byte per frame, with a per-grant burst cap.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int IDW       = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           uart_data_o,
  output logic                 uart_valid_o,
  input  logic                 uart_ready_i,
  input  logic                 uart_busy_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [IDW-1:0]       grant_id_o,
  output logic                 active_o,
  output logic                 abort_o
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_SEND      = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  localparam logic [7:0]         BURST_MAX = 8'(MAX_BURST);
  localparam logic [IDW-1:0]     ID_RST    = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0] NO_GRANT  = {NUM_REQ{1'b0}};

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [7:0]         burst_q, burst_d;
  logic               abort_q, abort_d;

  logic [IDW-1:0]     pick_s;
  logic               pick_vld_s;
  int                 dist_s;
  int                 best_s;
  logic               take_s;
  logic               sel_valid_s;
  logic               sel_last_s;
  logic [7:0]         sel_data_s;

  // Rotating-priority pick: the nearest valid requester after the last grant wins.
  always_comb begin
    pick_s     = gid_q;
    pick_vld_s = 1'b0;
    best_s     = NUM_REQ;
    dist_s     = 0;
    take_s     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      dist_s     = (k + 2 * NUM_REQ - int'(gid_q) - 1) % NUM_REQ;
      take_s     = req_valid_i[k] && (dist_s < best_s);
      best_s     = take_s ? dist_s : best_s;
      pick_s     = take_s ? IDW'(k) : pick_s;
      pick_vld_s = pick_vld_s | take_s;
    end
  end

  // Mux the granted requester's byte, valid and last flag.
  always_comb begin
    sel_data_s = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_data_s = sel_data_s | (req_data_i[8*k +: 8] & {8{grant_q[k]}});
    end
    sel_valid_s = |(req_valid_i & grant_q);
    sel_last_s  = |(req_last_i & grant_q);
  end

  // Ready is suppressed while disabled so no byte is consumed on the way back to IDLE.
  assign req_ready_o = ((state_q == ST_FETCH) && cfg_en_i) ? (req_valid_i & grant_q) : NO_GRANT;

  // Next-state logic for the byte sequencer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    burst_d = burst_q;
    abort_d = 1'b0;
    if (!cfg_en_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      grant_d = NO_GRANT;
      valid_d = 1'b0;
      abort_d = (state_q != ST_FETCH);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_en_i && pick_vld_s) begin
            state_d = ST_FETCH;
            grant_d = ONE_HOT0 << pick_s;
            gid_d   = pick_s;
            burst_d = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (sel_valid_s) begin
            data_d  = sel_data_s;
            last_d  = sel_last_s;
            burst_d = burst_q + 8'd1;
            valid_d = 1'b1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_SEND: begin
          if (valid_q && uart_ready_i) begin
            valid_d = 1'b0;
            state_d = ST_WAIT_BUSY;
          end else begin
            state_d = ST_SEND;
          end
        end
        ST_WAIT_BUSY: begin
          if (uart_busy_i) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            state_d = ST_WAIT_BUSY;
          end
        end
        ST_WAIT_IDLE: begin
          if (uart_busy_i) begin
            state_d = ST_WAIT_IDLE;
          end else if (last_q || (burst_q == BURST_MAX)) begin
            grant_d = NO_GRANT;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = NO_GRANT;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers; grant_id resets to the top index so requester 0 goes first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= NO_GRANT;
      gid_q   <= ID_RST;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      burst_q <= 8'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      abort_q <= abort_d;
    end
  end

  assign grant_o      = grant_q;
  assign grant_id_o   = gid_q;
  assign uart_data_o  = data_q;
  assign uart_valid_o = valid_q;
  assign active_o     = (state_q != ST_IDLE);
  assign abort_o      = abort_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte-stream requesters.
- Sits in front of the UART TX datapath. Drives its data/valid inputs, consumes its ready/busy outputs and sequences one byte at a time through the full frame.
- Grants are packet-locked, capped at MAX_BURST bytes per grant for fairness.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, max bytes sent per grant before the lock is forcibly released (1..255).
- IDW, 2, width of grant index; must be >= clog2(NUM_REQ).

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- cfg_en_i  input  1  UART enable; same signal fed to the transmitter.
- req_valid_i  input  NUM_REQ  per-requester byte valid.
- req_data_i  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- req_last_i  input  NUM_REQ  byte is last of packet.
- req_ready_o  output  NUM_REQ  per-requester byte accepted (one-hot or zero).
- uart_data_o  output  8  byte to transmitter data input.
- uart_valid_o  output  1  to transmitter valid input.
- uart_ready_i  input  1  transmitter ready (high in its idle state).
- uart_busy_i  input  1  transmitter busy (frame in progress).
- grant_o  output  NUM_REQ  one-hot current grant, zero when none.
- grant_id_o  output  IDW  index of current/last grant.
- active_o  output  1  high in any state except IDLE.
- abort_o  output  1  one-cycle pulse when a held byte is dropped by cfg_en_i deassertion.

Behaviour:
- Reset values:
  - Outputs: state IDLE, grant_o=0, grant_id_o=NUM_REQ-1 (so requester 0 has first priority), uart_data_o=8'h00, uart_valid_o=0, req_ready_o=0, active_o=0, abort_o=0.
  - Internal: burst_cnt=0, last_q=0.
- IDLE:
  - If cfg_en_i and |req_valid_i, select the first valid requester scanning from grant_id_o+1 upward, with modulo NUM_REQ wrap.
  - Next edge: grant_o and grant_id_o are registered, burst_cnt=0, go to FETCH.
  - Arbitration latency is 1 cycle.
- FETCH:
  - req_ready_o[g] = req_valid_i[g] (combinational, same cycle).
  - On handshake: latch byte into uart_data_o, latch last_q=req_last_i[g], increment burst_cnt, go to SEND.
  - With no valid, stay in FETCH. The lock is held while the packet is open.
- SEND:
  - uart_valid_o=1, data held stable.
  - Transfer occurs on uart_valid_o && uart_ready_i. uart_valid_o drops the following cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for uart_busy_i=1, then go to WAIT_IDLE. This accommodates the transmitter's 1-cycle state-register latency.
- WAIT_IDLE: wait for uart_busy_i=0 (frame complete, stop bits included). Then:
  - If last_q=1 or burst_cnt==MAX_BURST: release. grant_o=0, go to IDLE; grant_id_o retains value for rotation.
  - Otherwise go to FETCH with the same grant.
- No new byte is accepted from any requester while a frame is in flight; at most one byte is held.
- cfg_en_i low:
  - In any non-IDLE state: next edge go to IDLE, clear grant_o and uart_valid_o.
  - If a byte was latched but its frame not completed (SEND/WAIT_BUSY/WAIT_IDLE), pulse abort_o for 1 cycle.
  - In FETCH, no pulse.
- Simultaneous requests: only the rotating pointer decides; the requester just served has lowest priority next round.
- Burst cap mid-packet releases the lock; the requester's remaining bytes resume on its next grant.
- A requester deasserting req_valid_i in FETCH is not an error.
- Reset mid-frame: all state is cleared immediately (async). uart_valid_o=0; no abort_o pulse.
- Frames are sent back-to-back with no cycle gap beyond FETCH/SEND handshake.
- Per-byte controller overhead: 2 cycles (FETCH, SEND) when ready is already high.

Test Plan:
- Single requester 0 sends 3-byte packet 8'hA5, 8'h3C, 8'hF0 (last on third); cfg_div=4, 8 data bits, 1 stop bit.
  -> Three frames with exactly those bytes in order. grant_o=4'b0001 throughout, then 0. active_o drops after the third busy falls.
- Requesters 1 and 2 both valid from reset, 1-byte packets each.
  -> Requester 1 is granted first, then 2. A second round with 0 and 3 valid grants 3 before 0.
- Requester 0 streams a 20-byte packet with MAX_BURST=16 while requester 2 is valid.
  -> Grant released after byte 16. Requester 2's packet is sent, then requester 0 resumes with byte 17.
- cfg_en_i dropped for 1 cycle during WAIT_IDLE of byte 2.
  -> abort_o pulses once, state is IDLE next edge, grant_o=0. On re-enable, arbitration restarts from grant_id_o+1.
- rst_i asserted while in SEND.
  -> uart_valid_o, grant_o and req_ready_o are 0 asynchronously. After release, requester 0 has priority.
- Requester holds req_valid_i low for 10 cycles mid-packet.
  -> Arbiter stays in FETCH with grant held. Other valid requesters are not granted until last or burst cap.
